game_seq: RTL and testbench

Top-level game sequencer for the flappy game. It owns the one-hot game state that the pillar, bird and score datapaths consume, and it debounces the player button into flap/start pulses. It decides death from per-pixel pillar/bird overlap and bird height, enforces a game-over lockout, and keeps the session best score. It sits between the board button/video timing and the pillar/bird blocks on the pixel clock domain.

---
 rtl/game_seq.sv | 168 ++++++++++++++++
 tb/tb_game_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq.sv
// Flappy game sequencer: debounced button, one-hot READY/PLAY/OVER FSM, death detect, session best score.
// Latency: all outputs registered; press is 1 cycle after debounce terminal, flap/state 1 cycle after press.
// No backpressure: every input is sampled each clk cycle. Optional PAUSE state behind GAME_PAUSE_EN.
module game_seq #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FLOOR_Y         = 700,
    parameter int OVER_FRAMES     = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn,
    input  logic        hit_px,
    input  logic [10:0] bird_y,
    input  logic [13:0] score,
    output logic [2:0]  state,
    output logic        frame_en,
    output logic        flap,
    output logic [13:0] best,
    output logic        dead_flag
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LW = (OVER_FRAMES > 0) ? $clog2(OVER_FRAMES + 1) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(OVER_FRAMES);
    localparam logic [10:0]   FLOOR    = 11'(FLOOR_Y);

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2
`ifdef GAME_PAUSE_EN
        , S_PAUSE = 2'd3
`endif
    } fsm_t;

    fsm_t          fsm;
    logic [DW-1:0] db_cnt;
    logic          btn_lvl;
    logic          press;
    logic          hit_lat;
    logic [LW-1:0] lock_cnt;
    logic          dying;
`ifdef GAME_PAUSE_EN
    logic [4:0]    hold_cnt;
    logic          hold_arm;
`endif

    // Death is only decided on a frame boundary, using the latched and live overlap plus the floor test.
    assign dying = frame_tick && (hit_lat || hit_px || (bird_y >= FLOOR));

    // Debounce: count consecutive samples that disagree with the accepted level; accept on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt  <= '0;
            btn_lvl <= 1'b0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn == btn_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt  <= '0;
                btn_lvl <= btn;
                press   <= btn;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Game FSM with registered one-hot state, pulses, lockout counter and best score.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_READY;
            state     <= 3'b001;
            frame_en  <= 1'b0;
            flap      <= 1'b0;
            best      <= '0;
            dead_flag <= 1'b0;
            hit_lat   <= 1'b0;
            lock_cnt  <= '0;
`ifdef GAME_PAUSE_EN
            hold_cnt  <= '0;
            hold_arm  <= 1'b0;
`endif
        end else begin
            flap      <= 1'b0;
            dead_flag <= 1'b0;
            // OVER also passes the tick through so the pillar block can re-initialise.
            frame_en  <= frame_tick;
            case (fsm)
                S_READY: begin
                    hit_lat <= 1'b0;
                    if (press) begin
                        fsm   <= S_PLAY;
                        state <= 3'b010;
                        flap  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (frame_tick) begin
                        hit_lat <= 1'b0;
                    end else if (hit_px) begin
                        hit_lat <= 1'b1;
                    end
                    // Death takes priority over a coincident press: no flap on the dying cycle.
                    if (dying) begin
                        fsm       <= S_OVER;
                        state     <= 3'b100;
                        dead_flag <= 1'b1;
                        lock_cnt  <= '0;
                        if (score > best) begin
                            best <= score;
                        end
                    end else begin
`ifdef GAME_PAUSE_EN
                        if (press) begin
                            flap     <= 1'b1;
                            hold_cnt <= '0;
                            hold_arm <= 1'b1;
                        end else if (!btn_lvl) begin
                            hold_arm <= 1'b0;
                        end else if (hold_arm && frame_tick) begin
                            if (hold_cnt == 5'd31) begin
                                fsm      <= S_PAUSE;
                                frame_en <= 1'b0;
                                hold_arm <= 1'b0;
                            end else begin
                                hold_cnt <= hold_cnt + 5'd1;
                            end
                        end
`else
                        if (press) begin
                            flap <= 1'b1;
                        end
`endif
                    end
                end
                S_OVER: begin
                    hit_lat <= 1'b0;
                    if (press && (lock_cnt == LOCK_MAX)) begin
                        fsm   <= S_READY;
                        state <= 3'b001;
                    end
                    if (frame_tick && (lock_cnt < LOCK_MAX)) begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
`ifdef GAME_PAUSE_EN
                // Paused: frame logic frozen, hit_lat held, visible state stays PLAY.
                S_PAUSE: begin
                    frame_en <= 1'b0;
                    if (press) begin
                        fsm <= S_PLAY;
                    end
                end
`endif
                default: begin
                    fsm   <= S_READY;
                    state <= 3'b001;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_seq.sv
// Self-checking bench for game_seq: directed vector table, hand-written corner sequences,
// and a randomized phase compared every cycle against a behavioural model.
module tb_game_seq;

    localparam int D  = 4;
    localparam int FY = 700;
    localparam int OF = 60;
    localparam int FP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn = 1'b0;
    logic        hit_px = 1'b0;
    logic [10:0] bird_y = 11'd100;
    logic [13:0] score = '0;
    logic [2:0]  state;
    logic        frame_en;
    logic        flap;
    logic [13:0] best;
    logic        dead_flag;

    always #5 clk = ~clk;

    game_seq #(.DEBOUNCE_CYCLES(D), .FLOOR_Y(FY), .OVER_FRAMES(OF)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn), .hit_px(hit_px),
        .bird_y(bird_y), .score(score), .state(state), .frame_en(frame_en),
        .flap(flap), .best(best), .dead_flag(dead_flag)
    );

    int checks = 0;
    int errors = 0;
    int flap_cnt = 0;
    int dead_cnt = 0;

    // Behavioural model: game mode 0=READY 1=PLAY 2=OVER, button history window.
    int          m_mode = 0;
    int          m_over = 0;
    bit          m_hit = 0;
    bit          m_press = 0;
    bit          m_acc = 0;
    int          m_best = 0;
    bit          hist[$];
    logic [2:0]  e_state = 3'b001;
    logic        e_fe = 0, e_flap = 0, e_dead = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit died, all_diff, nxt_press;
        if (rst) begin
            m_mode = 0; m_over = 0; m_hit = 0; m_press = 0; m_acc = 0; m_best = 0;
            hist.delete();
            e_fe = 0; e_flap = 0; e_dead = 0; e_state = 3'b001;
            return;
        end
        e_fe = frame_tick; e_flap = 0; e_dead = 0;
        case (m_mode)
            0: begin
                m_hit = 0;
                if (m_press) begin m_mode = 1; e_flap = 1; end
            end
            1: begin
                died = frame_tick && (m_hit || hit_px || (int'(bird_y) >= FY));
                if (died) begin
                    m_mode = 2; e_dead = 1; m_over = 0; m_hit = 0;
                    if (int'(score) > m_best) m_best = int'(score);
                end else begin
                    if (m_press) e_flap = 1;
                    if (frame_tick) m_hit = 0;
                    else if (hit_px) m_hit = 1;
                end
            end
            default: begin
                m_hit = 0;
                if (m_press && m_over >= OF) m_mode = 0;
                if (frame_tick && m_over < OF) m_over++;
            end
        endcase
        e_state = 3'b001 << m_mode;
        // Button accepted once the last D samples all disagree with the accepted level.
        nxt_press = 0;
        hist.push_back(btn);
        if (hist.size() > D) void'(hist.pop_front());
        all_diff = (hist.size() == D);
        foreach (hist[i]) if (hist[i] == m_acc) all_diff = 0;
        if (all_diff) begin
            m_acc = btn;
            nxt_press = btn;
            hist.delete();
        end
        m_press = nxt_press;
    endtask

    task automatic cyc(input bit ft);
        frame_tick = ft;
        @(posedge clk);
        model_step();
        #1;
        chk("m_state", state, e_state);
        chk("m_frame_en", frame_en, e_fe);
        chk("m_flap", flap, e_flap);
        chk("m_dead", dead_flag, e_dead);
        chk("m_best", best, m_best);
        flap_cnt += flap;
        dead_cnt += dead_flag;
        frame_tick = 0;
    endtask

    task automatic press_btn();
        btn = 1; repeat (D + 2) cyc(0);
        btn = 0; repeat (D + 2) cyc(0);
    endtask

    task automatic frames(input int n);
        repeat (n) begin repeat (FP - 1) cyc(0); cyc(1); end
    endtask

    task automatic do_reset();
        rst = 1; cyc(0); rst = 0;
    endtask

    typedef struct {
        logic        hit;
        logic [10:0] y;
        logic [13:0] sc;
        logic [2:0]  st;
        logic [13:0] bst;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 11'd100,  14'd17, 3'b100, 14'd17};
        tbl[1] = '{1'b0, 11'd700,  14'd9,  3'b100, 14'd9};
        tbl[2] = '{1'b0, 11'd699,  14'd9,  3'b010, 14'd0};
        tbl[3] = '{1'b0, 11'd2047, 14'd3,  3'b100, 14'd3};
        tbl[4] = '{1'b0, 11'd0,    14'd0,  3'b010, 14'd0};
        tbl[5] = '{1'b1, 11'd699,  14'd0,  3'b100, 14'd0};

        // Reset state
        rst = 1; cyc(0); cyc(0); rst = 0;
        chk("rst_state", state, 3'b001);
        chk("rst_frame_en", frame_en, 0);
        chk("rst_flap", flap, 0);
        chk("rst_best", best, 0);
        chk("rst_dead", dead_flag, 0);

        // Glitch shorter than the debounce window: no effect
        flap_cnt = 0;
        btn = 1; repeat (D - 1) cyc(0);
        btn = 0; repeat (D + 2) cyc(0);
        chk("glitch_state", state, 3'b001);
        chk("glitch_flap", flap_cnt, 0);

        // Full press: exact latency, one flap
        flap_cnt = 0;
        btn = 1; repeat (D) cyc(0);
        chk("press_lat_state", state, 3'b001);
        cyc(0);
        chk("press_state", state, 3'b010);
        chk("press_flap", flap, 1);
        cyc(0);
        chk("press_flap_end", flap, 0);
        repeat (6) cyc(0);
        btn = 0; repeat (D + 2) cyc(0);
        chk("press_flap_once", flap_cnt, 1);

        // Vector table: one frame in PLAY with given hit/height/score
        foreach (tbl[k]) begin
            do_reset();
            bird_y = 11'd100; hit_px = 0; score = tbl[k].sc;
            press_btn();
            chk("tbl_play", state, 3'b010);
            bird_y = tbl[k].y;
            repeat (3) cyc(0);
            hit_px = tbl[k].hit; cyc(0); hit_px = 0;
            repeat (3) cyc(0);
            cyc(1);
            chk("tbl_state", state, tbl[k].st);
            chk("tbl_dead", dead_flag, (tbl[k].st == 3'b100) ? 1 : 0);
            chk("tbl_best", best, tbl[k].bst);
            cyc(0);
            chk("tbl_dead_end", dead_flag, 0);
            bird_y = 11'd100;
        end

        // Lockout boundaries and best retention
        do_reset();
        score = 14'd17; press_btn();
        hit_px = 1; cyc(0); hit_px = 0; cyc(1);
        chk("lk_over", state, 3'b100);
        chk("lk_best", best, 17);
        frames(10); press_btn();
        chk("lk_f10", state, 3'b100);
        frames(49); press_btn();
        chk("lk_f59", state, 3'b100);
        frames(1); press_btn();
        chk("lk_f60", state, 3'b001);
        score = 14'd5; press_btn();
        chk("g2_play", state, 3'b010);
        bird_y = 11'd750; cyc(0); cyc(1); bird_y = 11'd100;
        chk("g2_over", state, 3'b100);
        chk("g2_best", best, 17);

        // rst mid-PLAY clears best
        frames(OF); press_btn(); press_btn();
        chk("rp_play", state, 3'b010);
        chk("rp_best", best, 17);
        rst = 1; cyc(0); rst = 0;
        chk("rp_state", state, 3'b001);
        chk("rp_best0", best, 0);

        // Death and press on the same cycle: death wins, no flap
        score = 14'd9; press_btn();
        flap_cnt = 0;
        bird_y = 11'd800; btn = 1;
        repeat (D) cyc(0);
        cyc(1);
        chk("dp_state", state, 3'b100);
        chk("dp_dead", dead_flag, 1);
        chk("dp_flap", flap_cnt, 0);
        chk("dp_best", best, 9);
        btn = 0; bird_y = 11'd100; repeat (D + 2) cyc(0);

        // Randomized phase against the model
        do_reset();
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 9) == 0) btn = ~btn;
            hit_px = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0)
                bird_y = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(690, 2047))
                                                     : 11'($urandom_range(0, 699));
            if ($urandom_range(0, 19) == 0) score = 14'($urandom_range(0, 16383));
            cyc($urandom_range(0, 5) == 0);
        end
        hit_px = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
